// File: rtl/rand_ctrl_if.sv
// Signal bundle between rand_ctrl and its surroundings: raw keys and seed
// switches in, LFSR control (load/seed/step) and run status out.
interface rand_ctrl_if;
    logic       key_load;
    logic       key_run;
    logic [7:0] sw;
    logic       load;
    logic [7:0] seed;
    logic       step;
    logic       running;

    modport master (
        output key_load, key_run, sw,
        input  load, seed, step, running
    );

    modport slave (
        input  key_load, key_run, sw,
        output load, seed, step, running
    );
endinterface

// File: rtl/rand_ctrl.sv
// Control front-end for an 8-bit LFSR: debounces the load and run/pause keys,
// delivers the switch seed with a two-cycle load sequence and paces step strobes.
module rand_ctrl #(
    parameter int DEB_CYCLES = 16,
    parameter int STEP_DIV   = 8
) (
    input  logic        clk,
    input  logic        reset,
    rand_ctrl_if.slave  bus
);

    localparam int KEYS     = 2;
    localparam int KEY_LOAD = 0;
    localparam int KEY_RUN  = 1;
    localparam int CNT_W    = $clog2(DEB_CYCLES + 1);
    localparam int DIV_W    = $clog2(STEP_DIV);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD1,
        LOAD2,
        RUN,
        PAUSE
    } state_e;

    // ------------------------------------------------------------------
    // Key conditioning: synchronizer, debouncer, press detector per key
    // ------------------------------------------------------------------
    logic [KEYS-1:0]  key_n;
    logic [KEYS-1:0]  sync1_q;
    logic [KEYS-1:0]  sync2_q;
    logic [KEYS-1:0]  deb_q;
    logic [KEYS-1:0]  deb_d;
    logic [KEYS-1:0]  press_q;
    logic [KEYS-1:0]  press_d;
    logic [CNT_W-1:0] cnt_q [KEYS];
    logic [CNT_W-1:0] cnt_d [KEYS];

    assign key_n = {bus.key_run, bus.key_load};

    // NOTE: every variable gets its default before any branch, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        for (int k = 0; k < KEYS; k++) begin
            deb_d[k]   = deb_q[k];
            press_d[k] = 1'b0;
            cnt_d[k]   = '0;
            // The edge that would take the count to DEB_CYCLES flips the level instead.
            if (sync2_q[k] != deb_q[k]) begin
                if (cnt_q[k] == CNT_LAST) begin
                    deb_d[k]   = sync2_q[k];
                    press_d[k] = ~sync2_q[k];
                end else begin
                    cnt_d[k] = cnt_q[k] + 1'b1;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
            deb_q   <= '1;
            press_q <= '0;
            // NOTE: the counter array is tiny control state, so it is reset explicitly like any other register.
            cnt_q   <= '{default: '0};
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    logic             load_ev;
    logic             run_ev;
    state_e           state_q;
    state_e           state_d;
    logic [7:0]       seed_q;
    logic [7:0]       seed_d;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             load_q;
    logic             load_d;
    logic             step_q;
    logic             step_d;

    assign load_ev = press_q[KEY_LOAD];
    assign run_ev  = press_q[KEY_RUN];

    always_comb begin
        state_d = state_q;
        seed_d  = seed_q;
        div_d   = div_q;

        // A load press overrides everything, including a simultaneous run press.
        if (load_ev) begin
            seed_d  = bus.sw;
            state_d = LOAD1;
        end else begin
            unique case (state_q)
                IDLE, PAUSE: begin
                    if (run_ev) begin
                        state_d = RUN;
                        div_d   = '0;
                    end
                end
                LOAD1: state_d = LOAD2;
                LOAD2: state_d = PAUSE;
                RUN: begin
                    if (run_ev) begin
                        state_d = PAUSE;
                    end else begin
                        div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Outputs are decoded from next state so the registers line up with the state they describe.
        load_d = (state_d == LOAD1) || (state_d == LOAD2);
        step_d = (state_d == LOAD2) || ((state_d == RUN) && (div_d == DIV_LAST));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            seed_q  <= 8'h00;
            div_q   <= '0;
            load_q  <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            seed_q  <= seed_d;
            div_q   <= div_d;
            load_q  <= load_d;
            step_q  <= step_d;
        end
    end

    assign bus.load    = load_q;
    assign bus.step    = step_q;
    assign bus.seed    = seed_q;
    assign bus.running = (state_q == RUN);

endmodule

// File: tb/tb_rand_ctrl.sv
// Self-checking bench for rand_ctrl: directed scenarios with literal expectations
// plus randomized key activity compared every cycle against a behavioural model.
module tb_rand_ctrl;

    localparam int DEB = 4;
    localparam int SD  = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    bit   chk_en = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    rand_ctrl_if bus ();

    rand_ctrl #(
        .DEB_CYCLES (DEB),
        .STEP_DIV   (SD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model. A key press is recognised once the last DEB
    // synchronised samples all disagree with the accepted level; the
    // sequencer reacts one cycle later. Steps in RUN fall on every
    // SD-th cycle counted from entry.
    // ------------------------------------------------------------------
    typedef enum int {M_IDLE, M_LOAD1, M_LOAD2, M_RUN, M_PAUSE} mstate_e;

    mstate_e    m_st;
    logic [7:0] m_seed;
    int         m_age;
    bit         m_deb  [2];
    bit         m_ev   [2];
    bit         m_hist [2][DEB+1];

    task automatic model_reset();
        m_st   = M_IDLE;
        m_seed = 8'h00;
        m_age  = 0;
        for (int k = 0; k < 2; k++) begin
            m_deb[k] = 1'b1;
            m_ev[k]  = 1'b0;
            for (int j = 0; j <= DEB; j++) m_hist[k][j] = 1'b1;
        end
    endtask

    task automatic model_step();
        bit nev [2];
        bit raw [2];
        bit all_diff;
        raw[0] = bus.key_load;
        raw[1] = bus.key_run;
        for (int k = 0; k < 2; k++) begin
            all_diff = 1'b1;
            for (int j = 1; j <= DEB; j++) if (m_hist[k][j] == m_deb[k]) all_diff = 1'b0;
            nev[k] = all_diff && m_deb[k];
            if (all_diff) m_deb[k] = ~m_deb[k];
            for (int j = DEB; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
            m_hist[k][0] = raw[k];
        end
        if (m_ev[0]) begin
            m_seed = bus.sw;
            m_st   = M_LOAD1;
        end else begin
            case (m_st)
                M_IDLE, M_PAUSE: if (m_ev[1]) begin m_st = M_RUN; m_age = 0; end
                M_LOAD1: m_st = M_LOAD2;
                M_LOAD2: m_st = M_PAUSE;
                M_RUN: if (m_ev[1]) m_st = M_PAUSE; else m_age++;
                default: m_st = M_IDLE;
            endcase
        end
        m_ev = nev;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) model_reset();
        else       model_step();
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("load",    bus.load,    (m_st == M_LOAD1) || (m_st == M_LOAD2));
            check("step",    bus.step,    (m_st == M_LOAD2) || ((m_st == M_RUN) && ((m_age % SD) == SD - 1)));
            check("running", bus.running, m_st == M_RUN);
            check("seed",    bus.seed,    m_seed);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change 1 time unit after the falling edge.
    // ------------------------------------------------------------------
    task automatic next();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_running(input logic lvl, input string name);
        for (int i = 0; i < 30 && bus.running !== lvl; i++) next();
        check(name, bus.running, lvl);
    endtask

    task automatic wait_load(input string name);
        for (int i = 0; i < 30 && bus.load !== 1'b1; i++) next();
        check(name, bus.load, 1'b1);
    endtask

    task automatic load_sequence(input string name);
        logic [2:0] lseq;
        logic [2:0] sseq;
        for (int i = 2; i >= 0; i--) begin
            lseq[i] = bus.load;
            sseq[i] = bus.step;
            next();
        end
        check({name, "_load_seq"}, lseq, 3'b110);
        check({name, "_step_seq"}, sseq, 3'b010);
    endtask

    initial begin
        int lat;
        int bad;
        int steps[$];
        int rises;
        logic prev_run;

        bus.key_load = 1'b1;
        bus.key_run  = 1'b1;
        bus.sw       = 8'h00;
        next();
        next();
        chk_en = 1'b1;
        next();
        reset = 1'b0;

        // Quiet after reset
        bad = 0;
        repeat (20) begin
            next();
            if (bus.load || bus.step || bus.running || bus.seed != 8'h00) bad++;
        end
        check("idle_quiet_cycles", bad, 0);

        // Seed load; press latency is DEB+2 edges plus one for the sequencer
        bus.sw       = 8'h5A;
        bus.key_load = 1'b0;
        lat = 0;
        for (int i = 0; i < 30 && bus.load !== 1'b1; i++) begin
            next();
            lat++;
        end
        check("press_latency", lat, DEB + 3);
        load_sequence("seed5a");
        bus.key_load = 1'b1;
        check("seed_5a", bus.seed, 8'h5A);
        check("paused_after_load", bus.running, 1'b0);
        bad = 0;
        repeat (15) begin
            next();
            if (bus.load) bad++;
        end
        check("no_load_on_release", bad, 0);

        // Run, step cadence, pause
        bus.key_run = 1'b0;
        wait_running(1'b1, "run_enter");
        bus.key_run = 1'b1;
        for (int i = 1; i <= 13; i++) begin
            if (bus.step) steps.push_back(i);
            next();
        end
        check("step_count", steps.size(), 3);
        if (steps.size() == 3) begin
            check("step_1", steps[0], 4);
            check("step_2", steps[1], 8);
            check("step_3", steps[2], 12);
        end
        bus.key_run = 1'b0;
        wait_running(1'b0, "run_leave");
        bus.key_run = 1'b1;
        bad = 0;
        repeat (12) begin
            next();
            if (bus.step) bad++;
        end
        check("no_steps_paused", bad, 0);

        // Glitch shorter than DEB is ignored
        bus.sw       = 8'hFF;
        bus.key_load = 1'b0;
        repeat (DEB - 1) next();
        bus.key_load = 1'b1;
        bad = 0;
        repeat (15) begin
            next();
            if (bus.load) bad++;
        end
        check("glitch_no_load", bad, 0);
        check("glitch_seed_kept", bus.seed, 8'h5A);

        // Load and run together while running: load wins
        bus.key_run = 1'b0;
        wait_running(1'b1, "run_again");
        bus.key_run = 1'b1;
        repeat (10) next();
        bus.sw       = 8'hC3;
        bus.key_load = 1'b0;
        bus.key_run  = 1'b0;
        wait_load("dual_load_start");
        load_sequence("dual");
        bus.key_load = 1'b1;
        bus.key_run  = 1'b1;
        repeat (5) next();
        check("dual_running", bus.running, 1'b0);
        check("dual_seed", bus.seed, 8'hC3);

        // Reset during LOAD1 drops load at once
        bus.sw       = 8'h77;
        bus.key_load = 1'b0;
        wait_load("abort_load_start");
        bus.key_load = 1'b1;
        #2 reset = 1'b1;
        #1;
        check("abort_load_async", bus.load, 1'b0);
        check("abort_seed", bus.seed, 8'h00);
        next();
        next();
        reset = 1'b0;
        bad = 0;
        repeat (15) begin
            next();
            if (bus.load || bus.step || bus.running) bad++;
        end
        check("abort_idle", bad, 0);

        // Key held through reset release yields exactly one press
        bus.key_run = 1'b0;
        next();
        reset = 1'b1;
        next();
        next();
        reset = 1'b0;
        rises    = 0;
        prev_run = bus.running;
        repeat (30) begin
            next();
            if (bus.running && !prev_run) rises++;
            prev_run = bus.running;
        end
        check("held_reset_events", rises, 1);
        check("held_reset_running", bus.running, 1'b1);
        bus.key_run = 1'b1;
        repeat (10) next();

        // Randomized key activity, checked cycle by cycle by the model
        for (int it = 0; it < 400; it++) begin
            int act;
            int len;
            act = $urandom_range(0, 9);
            len = $urandom_range(1, 2 * DEB);
            bus.sw = 8'($urandom_range(0, 255));
            case (act)
                0, 1, 2, 3: bus.key_load = 1'b0;
                4, 5, 6, 7: bus.key_run  = 1'b0;
                8: begin
                    bus.key_load = 1'b0;
                    bus.key_run  = 1'b0;
                end
                default: begin
                    if ($urandom_range(0, 3) == 0) begin
                        reset = 1'b1;
                        len   = $urandom_range(1, 3);
                    end
                end
            endcase
            repeat (len) next();
            bus.key_load = 1'b1;
            bus.key_run  = 1'b1;
            reset        = 1'b0;
            repeat ($urandom_range(0, 12)) next();
        end

        repeat (3) next();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
